// File: rtl/gradient_accum_pkg.sv
// gradient_accum_pkg: write-back causes, controller states and the saturating add
package gradient_accum_pkg;
    typedef enum logic [2:0] {
        CAUSE_NONE      = 3'd0,
        CAUSE_DIRECT    = 3'd1,
        CAUSE_THRESHOLD = 3'd2,
        CAUSE_MAX_UPD   = 3'd3,
        CAUSE_EVICT     = 3'd4,
        CAUSE_FLUSH     = 3'd5
    } wb_cause_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Sum of two sign-extended operands clamped to a w-bit signed range (w <= 63)
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a, input logic signed [63:0] b, input int unsigned w);
        logic signed [64:0] s, hi, lo;
        s  = 65'(a) + 65'(b);
        hi = (65'sd1 <<< (w - 1)) - 65'sd1;
        lo = -hi - 65'sd1;
        return (s > hi) ? hi[63:0] : (s < lo) ? lo[63:0] : s[63:0];
    endfunction
endpackage

// File: rtl/grad_set_store.sv
// grad_set_store: flop-based L1 storage with whole-set read, single-way write and per-set round-robin pointers
module grad_set_store #(
    parameter int SETS     = 64,
    parameter int NUM_WAYS = 4,
    parameter int SET_W    = 6,
    parameter int WAY_W    = 2,
    parameter int ADDR_W   = 32,
    parameter int ACC_W    = 32,
    parameter int CNT_W    = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [SET_W-1:0]                   rd_set,
    output logic [NUM_WAYS-1:0]                rd_valid,
    output logic [NUM_WAYS-1:0][ADDR_W-1:0]    rd_tag,
    output logic [NUM_WAYS-1:0][ACC_W-1:0]     rd_accum,
    output logic [NUM_WAYS-1:0][CNT_W-1:0]     rd_cnt,
    output logic [WAY_W-1:0]                   rd_rr,
    input  logic                               wr_en,
    input  logic [SET_W-1:0]                   wr_set,
    input  logic [WAY_W-1:0]                   wr_way,
    input  logic                               wr_valid,
    input  logic [ADDR_W-1:0]                  wr_tag,
    input  logic [ACC_W-1:0]                   wr_accum,
    input  logic [CNT_W-1:0]                   wr_cnt,
    input  logic                               rr_inc,
    input  logic                               clear_all
);
    logic [SETS-1:0][NUM_WAYS-1:0]              valid;
    logic [SETS-1:0][NUM_WAYS-1:0][ADDR_W-1:0]  tag;
    logic [SETS-1:0][NUM_WAYS-1:0][ACC_W-1:0]   accum;
    logic [SETS-1:0][NUM_WAYS-1:0][CNT_W-1:0]   cnt;
    logic [SETS-1:0][WAY_W-1:0]                 rr;

    assign rd_valid = valid[rd_set];
    assign rd_tag   = tag[rd_set];
    assign rd_accum = accum[rd_set];
    assign rd_cnt   = cnt[rd_set];
    assign rd_rr    = rr[rd_set];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            tag   <= '0;
            accum <= '0;
            cnt   <= '0;
            rr    <= '0;
        end else if (clear_all) begin
            valid <= '0;
            rr    <= '0;
        end else begin
            if (wr_en) begin
                valid[wr_set][wr_way] <= wr_valid;
                tag[wr_set][wr_way]   <= wr_tag;
                accum[wr_set][wr_way] <= wr_accum;
                cnt[wr_set][wr_way]   <= wr_cnt;
            end
            if (rr_inc)
                rr[wr_set] <= (rr[wr_set] == WAY_W'(NUM_WAYS - 1)) ? '0 : rr[wr_set] + WAY_W'(1);
        end
    end
endmodule

// File: rtl/gradient_accumulator_v2.sv
// gradient_accumulator_v2: set-associative L1 gradient accumulator pushing sums to L2 on threshold,
// update limit, eviction or flush
module gradient_accumulator_v2
    import gradient_accum_pkg::*;
#(
    parameter int GRAD_W      = 16,
    parameter int ACC_W       = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 256,
    parameter int NUM_WAYS    = 4,
    parameter int THRESHOLD   = 1000,
    parameter int MAX_UPDATES = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W-1:0]        in_addr,
    input  logic signed [GRAD_W-1:0] in_grad,
    input  logic                     flush_req,
    output logic                     flush_busy,
    output logic                     flush_done,
    output logic                     wb_push_valid,
    output logic [ADDR_W-1:0]        wb_push_addr,
    output logic signed [ACC_W-1:0]  wb_push_value,
    input  logic                     wb_push_ready,
    output logic [2:0]               wb_cause
);
    localparam int SETS  = DEPTH / NUM_WAYS;
    localparam int SET_W = SETS > 1 ? $clog2(SETS) : 1;
    localparam int WAY_W = NUM_WAYS > 1 ? $clog2(NUM_WAYS) : 1;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(MAX_UPDATES + 1);
    localparam logic [ACC_W-1:0] THR = ACC_W'(THRESHOLD);

    state_e state, state_nxt;
    logic [IDX_W-1:0] scan, scan_nxt;
    logic [SET_W-1:0] cur_set;
    logic [WAY_W-1:0] scan_way, hit_way, empty_way, wr_way, rd_rr;
    logic [NUM_WAYS-1:0] rd_valid;
    logic [NUM_WAYS-1:0][ADDR_W-1:0] rd_tag;
    logic [NUM_WAYS-1:0][ACC_W-1:0] rd_accum;
    logic [NUM_WAYS-1:0][CNT_W-1:0] rd_cnt;
    logic hit, empty, direct, sum_trig, cnt_trig, push, wr_en, wr_valid, evict;
    logic signed [ACC_W-1:0] grad_ext, hit_accum, new_accum, push_value, wr_accum;
    logic [ACC_W-1:0] grad_mag, sum_mag;
    logic [CNT_W-1:0] cnt_next, wr_cnt;
    logic [ADDR_W-1:0] push_addr;
    wb_cause_e cause;

    assign scan_way  = scan[WAY_W-1:0];
    assign cur_set   = (state == ST_FLUSH) ? scan[IDX_W-1:WAY_W] : in_addr[SET_W-1:0];
    assign grad_ext  = ACC_W'(in_grad);
    assign hit_accum = rd_accum[hit_way];
    assign new_accum = ACC_W'(sat_add(64'(hit_accum), 64'(grad_ext), ACC_W));
    // Unsigned magnitude maps the most-negative sum to 2^(ACC_W-1), so it always trips the threshold
    assign grad_mag  = grad_ext[ACC_W-1] ? -grad_ext : grad_ext;
    assign sum_mag   = new_accum[ACC_W-1] ? -new_accum : new_accum;
    assign direct    = grad_mag >= THR;
    assign sum_trig  = sum_mag >= THR;
    assign cnt_next  = rd_cnt[hit_way] + CNT_W'(1);
    assign cnt_trig  = cnt_next == CNT_W'(MAX_UPDATES);

    always_comb begin
        hit = 1'b0;
        hit_way = '0;
        empty = 1'b0;
        empty_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (rd_valid[w] && rd_tag[w] == in_addr) begin
                hit = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!rd_valid[w]) begin
                empty = 1'b1;
                empty_way = WAY_W'(w);
            end
        end
    end

    always_comb begin
        push = 1'b0;
        cause = CAUSE_NONE;
        push_addr = in_addr;
        push_value = grad_ext;
        wr_en = 1'b0;
        wr_way = hit_way;
        wr_valid = 1'b1;
        wr_accum = grad_ext;
        wr_cnt = CNT_W'(1);
        evict = 1'b0;
        in_ready = 1'b0;
        state_nxt = state;
        scan_nxt = scan;
        case (state)
            ST_IDLE: begin
                if (direct) begin
                    push = 1'b1;
                    cause = CAUSE_DIRECT;
                end else if (hit) begin
                    push = sum_trig || cnt_trig;
                    cause = sum_trig ? CAUSE_THRESHOLD : cnt_trig ? CAUSE_MAX_UPD : CAUSE_NONE;
                    push_value = new_accum;
                    wr_valid = !(sum_trig || cnt_trig);
                    wr_accum = new_accum;
                    wr_cnt = cnt_next;
                end else if (empty) begin
                    wr_way = empty_way;
                end else begin
                    push = 1'b1;
                    cause = CAUSE_EVICT;
                    evict = 1'b1;
                    wr_way = rd_rr;
                    push_addr = rd_tag[rd_rr];
                    push_value = rd_accum[rd_rr];
                end
                push = push && in_valid && !flush_req;
                in_ready = !flush_req && (!push || wb_push_ready);
                wr_en = in_valid && in_ready && !direct;
                evict = evict && wr_en;
                state_nxt = flush_req ? ST_FLUSH : ST_IDLE;
            end
            ST_FLUSH: begin
                push = rd_valid[scan_way];
                cause = CAUSE_FLUSH;
                push_addr = rd_tag[scan_way];
                push_value = rd_accum[scan_way];
                wr_way = scan_way;
                wr_valid = 1'b0;
                wr_en = push && wb_push_ready;
                if (!push || wb_push_ready) begin
                    scan_nxt = scan + IDX_W'(1);
                    state_nxt = (scan == IDX_W'(DEPTH - 1)) ? ST_DONE : ST_FLUSH;
                end
            end
            ST_DONE: begin
                scan_nxt = '0;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            scan <= '0;
        end else begin
            state <= state_nxt;
            scan <= scan_nxt;
        end
    end

    assign flush_busy    = state == ST_FLUSH;
    assign flush_done    = state == ST_DONE;
    assign wb_push_valid = push;
    assign wb_push_addr  = push ? push_addr : '0;
    assign wb_push_value = push ? push_value : '0;
    assign wb_cause      = push ? cause : CAUSE_NONE;

    grad_set_store #(
        .SETS(SETS), .NUM_WAYS(NUM_WAYS), .SET_W(SET_W), .WAY_W(WAY_W),
        .ADDR_W(ADDR_W), .ACC_W(ACC_W), .CNT_W(CNT_W)
    ) u_store (
        .clk(clk), .rst_n(rst_n), .rd_set(cur_set),
        .rd_valid(rd_valid), .rd_tag(rd_tag), .rd_accum(rd_accum), .rd_cnt(rd_cnt), .rd_rr(rd_rr),
        .wr_en(wr_en), .wr_set(cur_set), .wr_way(wr_way), .wr_valid(wr_valid),
        .wr_tag(in_addr), .wr_accum(wr_accum), .wr_cnt(wr_cnt),
        .rr_inc(evict), .clear_all(state == ST_DONE)
    );
endmodule

// File: doc/gradient_accumulator_v2.md
GRADIENT_ACCUMULATOR_V2 -- requirements
Module: gradient_accumulator_v2

Interface
REQ-001 SHALL have parameter GRAD_W, default 16, signed input gradient width.
REQ-002 SHALL have parameter ACC_W, default 32, signed accumulator and push-value width; ACC_W > GRAD_W.
REQ-003 SHALL have parameter ADDR_W, default 32, address/tag width.
REQ-004 SHALL have parameters DEPTH (256), NUM_WAYS (4), THRESHOLD (1000, positive), MAX_UPDATES (255); the upd_cnt width is $clog2(MAX_UPDATES+1).
REQ-005 SHALL have these ports; one clock, reset asynchronous active-low:
  clk  in  1  clock
  rst_n  in  1  async active-low reset
  in_valid  in  1  gradient request
  in_ready  out  1  request accepted when in_valid&&in_ready
  in_addr  in  ADDR_W  gradient address
  in_grad  in  GRAD_W  signed gradient
  flush_req  in  1  level request to drain all L1 entries
  flush_busy  out  1  high in FLUSH state
  flush_done  out  1  one-cycle pulse at flush end
  wb_push_valid  out  1  L2 push
  wb_push_addr  out  ADDR_W  push address
  wb_push_value  out  ACC_W  signed push value
  wb_push_ready  in  1  L2 can accept
  wb_cause  out  3  0 none, 1 direct, 2 threshold, 3 max_updates, 4 eviction, 5 flush

Function
REQ-006 SHALL use FSM states IDLE, FLUSH, DONE; IDLE->FLUSH when flush_req=1; FLUSH->DONE after the last index is handled; DONE->IDLE unconditionally after 1 cycle.
REQ-007 In IDLE, in_ready SHALL be !flush_req && (!wb_needed || wb_push_ready); in FLUSH/DONE in_ready=0. flush_req has priority over input.
REQ-008 Set index = in_addr[log2(DEPTH/NUM_WAYS)-1:0]; tag = full in_addr; hit = valid way with tag match; lowest matching way wins.
REQ-009 Direct trigger: |sext(in_grad)| >= THRESHOLD -> push (addr, sext grad), cause 1; no L1 write.
REQ-010 Hit: new_accum = saturating sum of accum and sext(grad), clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
REQ-011 Hit with |new_accum| >= THRESHOLD -> push new_accum, cause 2, invalidate way; |most-negative| treated as max positive.
REQ-012 Hit with upd_cnt+1 == MAX_UPDATES (threshold not met) -> push new_accum, cause 3, invalidate way; otherwise write new_accum and upd_cnt+1.
REQ-013 Miss, empty way present -> allocate the lowest-index empty way with accum = sext(grad), upd_cnt = 1; no push.
REQ-014 Miss, set full -> push the victim (tag, accum), cause 4, overwrite the victim with the new entry, and advance that set's round-robin pointer modulo NUM_WAYS.
REQ-015 A push or L1 write SHALL occur only in the accept cycle; when wb_push_ready=0, state is unchanged and no data is lost. The push is combinational (0-cycle latency) and the L1 update is visible next cycle.
REQ-016 FLUSH: scan index 0..DEPTH-1 (set*NUM_WAYS+way), one per cycle. For a valid entry: assert push with cause 5, hold until wb_push_ready, then invalidate and advance. For an invalid entry: skip and advance.
REQ-017 flush_done=1 exactly in DONE; after DONE all valid bits = 0, and all round-robin pointers = 0.
REQ-018 flush_req deasserting mid-flush SHALL NOT abort the flush.
REQ-019 wb_push_valid SHALL never assert without a corresponding cause != 0.

Reset
REQ-020 On rst_n low (any state, including mid-flush): state=IDLE; all valid bits, accums, upd_cnts, rr pointers and the scan index = 0. Outputs in_ready=1, flush_busy=0, flush_done=0, wb_push_valid=0, wb_push_addr=0, wb_push_value=0, wb_cause=0. Nothing in flight is pushed.

Structure
REQ-021 Package gradient_accum_pkg SHALL hold the wb_cause enum, the FSM state enum, and a sat_add function.
REQ-022 Storage SHALL be a sub-module grad_set_store, flop-based, with: async clear, one read port (whole set), one write port (one way), an rr-increment input, and a clear-all input.

Verification (GRAD_W=16, ACC_W=32, DEPTH=16, NUM_WAYS=4, THRESHOLD=1000, MAX_UPDATES=4)
REQ-023 Addr 0x10, grad +600 then +500 -> second accept pushes (0x10, 1100), cause 2; entry invalid afterwards.
REQ-024 Addr 0x20, grad -1200 -> immediate push (0x20, -1200), cause 1; next grad +10 to 0x20 allocates (miss, no push).
REQ-025 Addrs 0x0,0x4,0x8,0xC,0x10 each +1 (set 0) -> fifth pushes (0x0, 1), cause 4; rr pointer = 1.
REQ-026 Addr 0x5, grad +1 four times -> fourth pushes (0x5, 4), cause 3.
REQ-027 Three entries valid, flush_req with wb_push_ready toggling 1/0 -> three cause-5 pushes in index order, flush_done one pulse, in_ready=0 throughout, L1 empty afterwards.
REQ-028 Assert rst_n=0 mid-flush -> outputs at reset values next edge; a subsequent flush pushes nothing.
